// File: rtl/game_judge_pkg.sv
// Shared types and constants for the tic-tac-toe judge: cell and result codes,
// FSM states and the line-level helper functions.
package game_pkg;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] CELL_X = 2'b01;
  localparam logic [1:0] CELL_O = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam int         NUM_LINES = 8;
  localparam logic [3:0] NO_LINE   = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    FULLCHK = 2'd2,
    REPORT  = 2'd3
  } state_e;

  // Only real player marks can win; the invalid code 11 never does.
  function automatic logic line_wins(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c);
    return (a == b) && (b == c) && ((a == CELL_X) || (a == CELL_O));
  endfunction

  function automatic logic board_full(input logic [8:0][1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ok = ok & (b[i] != EMPTY);
    end
    return ok;
  endfunction

endpackage

// File: rtl/game_judge_win_line_lut.sv
// Combinational map from a win-line index to the three board cells it covers.
module win_line_lut
  import game_pkg::*;
(
  input  logic [2:0] line_idx,
  output logic [3:0] cell_a,
  output logic [3:0] cell_b,
  output logic [3:0] cell_c
);

  always_comb begin
    case (line_idx)
      3'd0:    {cell_a, cell_b, cell_c} = {4'd0, 4'd1, 4'd2};
      3'd1:    {cell_a, cell_b, cell_c} = {4'd3, 4'd4, 4'd5};
      3'd2:    {cell_a, cell_b, cell_c} = {4'd6, 4'd7, 4'd8};
      3'd3:    {cell_a, cell_b, cell_c} = {4'd0, 4'd3, 4'd6};
      3'd4:    {cell_a, cell_b, cell_c} = {4'd1, 4'd4, 4'd7};
      3'd5:    {cell_a, cell_b, cell_c} = {4'd2, 4'd5, 4'd8};
      3'd6:    {cell_a, cell_b, cell_c} = {4'd0, 4'd4, 4'd8};
      3'd7:    {cell_a, cell_b, cell_c} = {4'd2, 4'd4, 4'd6};
      default: {cell_a, cell_b, cell_c} = {4'd0, 4'd1, 4'd2};
    endcase
  end

endmodule

// File: rtl/game_judge.sv
// Sequential tic-tac-toe judge: snapshots the board, scans one line per cycle,
// then reports winner / draw. Optional win_line output under WIN_LINE_REPORT_EN.
module game_judge
  import game_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [8:0][1:0] board,
  output logic            busy,
  output logic            done,
  output logic [1:0]      result
`ifdef WIN_LINE_REPORT_EN
  ,
  output logic [3:0]      win_line
`endif
);

  state_e          state_q,  state_d;
  logic [8:0][1:0] snap_q,   snap_d;
  logic [2:0]      idx_q,    idx_d;
  logic            found_q,  found_d;
  logic [1:0]      winner_q, winner_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [1:0]      result_q, result_d;
`ifdef WIN_LINE_REPORT_EN
  logic [3:0]      win_idx_q,  win_idx_d;
  logic [3:0]      win_line_q, win_line_d;
`endif

  logic [3:0] cell_a, cell_b, cell_c;
  logic       hit_s;

  win_line_lut u_lut (
    .line_idx (idx_q),
    .cell_a   (cell_a),
    .cell_b   (cell_b),
    .cell_c   (cell_c)
  );

  assign hit_s = line_wins(snap_q[cell_a], snap_q[cell_b], snap_q[cell_c]);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    found_d  = found_q;
    winner_d = winner_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef WIN_LINE_REPORT_EN
    win_idx_d  = win_idx_q;
    win_line_d = win_line_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          snap_d   = board;
          idx_d    = 3'd0;
          found_d  = 1'b0;
          winner_d = RES_NONE;
          result_d = RES_NONE;
          busy_d   = 1'b1;
`ifdef WIN_LINE_REPORT_EN
          win_idx_d = NO_LINE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Only the lowest-index winning line counts, even on illegal boards.
        if (hit_s && !found_q) begin
          found_d  = 1'b1;
          winner_d = snap_q[cell_a];
`ifdef WIN_LINE_REPORT_EN
          win_idx_d = {1'b0, idx_q};
`endif
        end else begin
          found_d = found_q;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(NUM_LINES - 1)) begin
          state_d = FULLCHK;
        end else begin
          state_d = SCAN;
        end
      end
      FULLCHK: begin
        if (found_q) begin
          result_d = winner_q;
        end else if (board_full(snap_q)) begin
          result_d = RES_DRAW;
        end else begin
          result_d = RES_NONE;
        end
`ifdef WIN_LINE_REPORT_EN
        win_line_d = found_q ? win_idx_q : NO_LINE;
`endif
        state_d = REPORT;
      end
      REPORT: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      idx_q    <= 3'd0;
      found_q  <= 1'b0;
      winner_q <= RES_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= RES_NONE;
`ifdef WIN_LINE_REPORT_EN
      win_idx_q  <= NO_LINE;
      win_line_q <= NO_LINE;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      winner_q <= winner_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef WIN_LINE_REPORT_EN
      win_idx_q  <= win_idx_d;
      win_line_q <= win_line_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef WIN_LINE_REPORT_EN
  assign win_line = win_line_q;
`endif

endmodule

// File: tb/tb_game_judge.sv
// Directed scoreboard bench for game_judge; win_line checks follow WIN_LINE_REPORT_EN.
module tb_game_judge;
  import game_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [8:0][1:0] board;
  logic            busy;
  logic            done;
  logic [1:0]      result;
`ifdef WIN_LINE_REPORT_EN
  logic [3:0]      win_line;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] res;
    logic [3:0] line;
  } exp_t;
  exp_t sb[$];

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] I = 2'b11;

  game_judge dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .board  (board),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef WIN_LINE_REPORT_EN
    ,
    .win_line (win_line)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0][1:0] b9(input logic [1:0] c0, input logic [1:0] c1,
      input logic [1:0] c2, input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5,
      input logic [1:0] c6, input logic [1:0] c7, input logic [1:0] c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check_line(input string tag, input logic [3:0] exp_line);
`ifdef WIN_LINE_REPORT_EN
    chk({tag, "_line"}, {28'd0, win_line}, {28'd0, exp_line});
`endif
  endtask

  // One evaluation: start, scramble board during scan, wait bounded for done.
  task automatic run_eval(input string tag, input logic [8:0][1:0] b,
                          input logic [1:0] r, input logic [3:0] l);
    int   lat;
    exp_t e;
    @(negedge clk);
    board = b;
    start = 1'b1;
    sb.push_back('{res: r, line: l});
    @(posedge clk);
    #1;
    start = 1'b0;
    board = ~b;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd10);
    e = sb.pop_front();
    if (done) begin
      chk({tag, "_res"}, {30'd0, result}, {30'd0, e.res});
      check_line(tag, e.line);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hold"}, {30'd0, result}, {30'd0, e.res});
    end else begin
      chk({tag, "_no_done"}, {31'd0, done}, 32'd1);
    end
  endtask

  initial begin
    logic [8:0][1:0] b_keep;
    logic [8:0][1:0] b_noise;
    exp_t            e;
    int              n_done;
    int              first_c;
    int              second_c;

    rst   = 1'b1;
    start = 1'b0;
    board = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {30'd0, result}, 32'd0);
    check_line("rst", NO_LINE);
    @(negedge clk);
    rst = 1'b0;

    run_eval("x_row0",  b9(X, X, X, O, O, E, E, E, E), RES_X,    4'd0);
    run_eval("o_diag7", b9(X, X, O, X, O, E, O, E, E), RES_O,    4'd7);
    run_eval("draw",    b9(X, O, X, X, O, O, O, X, X), RES_DRAW, NO_LINE);
    run_eval("both",    b9(X, X, X, E, E, E, O, O, O), RES_X,    4'd0);
    run_eval("inv_row", b9(I, I, I, E, E, E, E, E, E), RES_NONE, NO_LINE);
    run_eval("all_inv", b9(I, I, I, I, I, I, I, I, I), RES_DRAW, NO_LINE);
    run_eval("empty",   b9(E, E, E, E, E, E, E, E, E), RES_NONE, NO_LINE);
    run_eval("o_col4",  b9(E, O, X, E, O, X, E, O, E), RES_O,    4'd4);

    // Back-to-back start requests: only IDLE-edge starts are accepted.
    b_keep  = b9(E, O, X, E, O, X, E, O, E);
    b_noise = b9(X, X, X, E, E, E, E, E, E);
    sb.push_back('{res: RES_O, line: 4'd4});
    sb.push_back('{res: RES_O, line: 4'd4});
    n_done   = 0;
    first_c  = -1;
    second_c = -1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      start = (c < 20);
      board = (c == 0 || c == 11) ? b_keep : b_noise;
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) first_c = c;
        else second_c = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("burst_res", {30'd0, result}, {30'd0, e.res});
          check_line("burst", e.line);
        end else begin
          chk("burst_extra", n_done, 32'd2);
        end
      end
    end
    start = 1'b0;
    chk("burst_count", n_done, 32'd2);
    chk("burst_first", first_c, 32'd10);
    chk("burst_space", second_c - first_c, 32'd11);
    sb.delete();

    // Async reset while idle clears the held result.
    run_eval("pre_rst", b9(X, X, X, O, O, E, E, E, E), RES_X, 4'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("idle_rst_res", {30'd0, result}, 32'd0);
    check_line("idle_rst", NO_LINE);
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the fourth scan cycle.
    @(negedge clk);
    board = b9(O, O, O, E, E, E, X, X, E);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_res", {30'd0, result}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_eval("post_rst", b9(O, O, O, E, E, E, X, X, E), RES_O, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_judge.md
GAME_JUDGE -- requirements
Module: game_judge

Interface
REQ-001 SHALL have no parameters; board size fixed at 9 cells x 2 bits, 8 win lines.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  evaluation request, sampled on rising clk.
REQ-005 SHALL have port: board  input  9x2 (packed [8:0][1:0])  cell i = board[i]; 00 empty, 01 X, 10 O, 11 invalid.
REQ-006 SHALL have port: busy  output  1  high while an evaluation is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, evaluation complete.
REQ-008 SHALL have port: result  output  2  00 none/playing, 01 X wins, 10 O wins, 11 draw.
REQ-009 SHALL have port (only with WIN_LINE_REPORT_EN): win_line  output  4  winning line index 0-7, 15 = none.

Function
REQ-010 SHALL implement FSM states IDLE, SCAN, FULLCHK, REPORT.
REQ-011 IDLE: start=1 -> capture board into internal snapshot, clear result to 00, line index to 0, busy=1, go SCAN.
REQ-012 SCAN: evaluate one line per cycle, index 0..7; after index 7 go FULLCHK.
REQ-013 Line table: 0{0,1,2} 1{3,4,5} 2{6,7,8} 3{0,3,6} 4{1,4,7} 5{2,5,8} 6{0,4,8} 7{2,4,6}.
REQ-014 Line wins iff its three snapshot cells are equal and equal 01 or 10; 11 never wins.
REQ-015 First winning line (lowest index) recorded; later wins ignored, including opposite player (illegal board).
REQ-016 SCAN always runs all 8 lines; no early exit, latency fixed.
REQ-017 FULLCHK: if win recorded, result = winner code; else if no snapshot cell is 00, result = 11; else result = 00.
REQ-018 REPORT: done=1 for exactly one cycle, busy=0, next state IDLE.
REQ-019 Latency: start sampled at edge E -> done high in the cycle following edge E+10; result valid from same edge.
REQ-020 start while not in IDLE SHALL be ignored; no queuing.
REQ-021 start high in the done cycle SHALL be accepted (FSM is in IDLE after REPORT edge? no: REPORT lasts one cycle, start accepted only on the edge leaving IDLE).
REQ-022 board changes after capture SHALL NOT affect the current evaluation.
REQ-023 result SHALL hold its value between evaluations until the next accepted start.

Reset
REQ-024 rst asserted at any time, including mid-SCAN, SHALL immediately force IDLE, busy=0, done=0, result=00, win_line=15, snapshot=0, index=0.
REQ-025 First start after rst deassertion SHALL be accepted on the first rising edge where rst is low.

Configuration
REQ-026 Macro WIN_LINE_REPORT_EN: when defined, port win_line exists, loads winning index in FULLCHK (15 if none/draw), holds like result.
REQ-027 Without WIN_LINE_REPORT_EN: port absent, no index-capture register, all other behaviour identical.

Structure
REQ-028 Shared package game_pkg SHALL hold: cell codes (EMPTY=00, CELL_X=01, CELL_O=10), result codes (RES_NONE, RES_X, RES_O, RES_DRAW), FSM state enum, NUM_LINES=8, NO_LINE=15.
REQ-029 Sub-module win_line_lut SHALL map 3-bit line index to three 4-bit cell indices (combinational, REQ-013 table).

Verification
REQ-030 Board X on cells 0,1,2, O on 3,4, rest empty; start -> done after 10 cycles, result=01, win_line=0.
REQ-031 Board O on 2,4,6, X on 0,1,3, rest empty -> result=10, win_line=7.
REQ-032 Full board X,O,X,X,O,O,O,X,X (cells 0-8), no line -> result=11, win_line=15.
REQ-033 Both X row 0 and O row 2 present -> result=01, win_line=0; cells 11,11,11 row -> no win.
REQ-034 start pulses every cycle for 20 cycles -> exactly two done pulses spaced 11 cycles; board toggled mid-SCAN has no effect.
REQ-035 rst asserted in 4th SCAN cycle -> busy, done, result clear asynchronously; new start completes normally.
